// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, req/ack instruction-memory fetch, valid/ready hand-off to decode.
// Optional build macro FETCH_COUNT_EN compiles in the accepted-instruction counter.
module instr_fetch_unit #(
  parameter int unsigned        ADDRLEN   = 32,
  parameter int unsigned        INSTRLEN  = 32,
  parameter int unsigned        OPCODELEN = 7,
  parameter logic [ADDRLEN-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imemReq,
  output logic [ADDRLEN-1:0]   imemAddr,
  input  logic                 imemAck,
  input  logic [INSTRLEN-1:0]  imemData,
  input  logic                 branchTaken,
  input  logic [ADDRLEN-1:0]   branchTarget,
  output logic                 instrValid,
  input  logic                 instrReady,
  output logic [INSTRLEN-1:0]  instr,
  output logic [OPCODELEN-1:0] opcode,
  output logic [ADDRLEN-1:0]   pcOut,
  output logic [31:0]          fetchCount
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [ADDRLEN-1:0] PC_STEP = ADDRLEN'(3'd4);

  logic [1:0]          state_r, state_n;
  logic [ADDRLEN-1:0]  pc_r, pc_n;
  logic [ADDRLEN-1:0]  addr_r, addr_n;
  logic                flush_r, flush_n;
  logic                req_r, req_n;
  logic                valid_r, valid_n;
  logic [INSTRLEN-1:0] instr_r, instr_n;
  logic [ADDRLEN-1:0]  pcout_r, pcout_n;
  logic                accept_s;
  logic [ADDRLEN-1:0]  target_s;
  logic [ADDRLEN-1:0]  pc_inc_s;
  logic                unused_s;

  assign target_s = {branchTarget[ADDRLEN-1:2], 2'b00};
  assign pc_inc_s = pc_r + PC_STEP;

  // Next-state logic; a redirect outranks ack and accept in every state.
  always_comb begin
    state_n  = state_r;
    pc_n     = pc_r;
    addr_n   = addr_r;
    flush_n  = flush_r;
    req_n    = req_r;
    valid_n  = valid_r;
    instr_n  = instr_r;
    pcout_n  = pcout_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_n = ST_REQ;
        req_n   = 1'b1;
        if (branchTaken) begin
          pc_n   = target_s;
          addr_n = target_s;
        end else begin
          addr_n = pc_r;
        end
      end
      ST_REQ: begin
        if (branchTaken && imemAck) begin
          pc_n    = target_s;
          addr_n  = target_s;
          flush_n = 1'b0;
        end else if (branchTaken) begin
          // keep the outstanding request at its old address until it is acked
          pc_n    = target_s;
          flush_n = 1'b1;
        end else if (imemAck && flush_r) begin
          flush_n = 1'b0;
          addr_n  = pc_r;
        end else if (imemAck) begin
          instr_n = imemData;
          pcout_n = addr_r;
          valid_n = 1'b1;
          req_n   = 1'b0;
          state_n = ST_HOLD;
        end else begin
          state_n = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (branchTaken) begin
          pc_n    = target_s;
          addr_n  = target_s;
          valid_n = 1'b0;
          req_n   = 1'b1;
          state_n = ST_REQ;
        end else if (instrReady) begin
          accept_s = 1'b1;
          pc_n     = pc_inc_s;
          addr_n   = pc_inc_s;
          valid_n  = 1'b0;
          req_n    = 1'b1;
          state_n  = ST_REQ;
        end else begin
          state_n = ST_HOLD;
        end
      end
      default: begin
        state_n = ST_IDLE;
        req_n   = 1'b0;
        valid_n = 1'b0;
        flush_n = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pc_r    <= RESET_PC;
      addr_r  <= RESET_PC;
      flush_r <= 1'b0;
      req_r   <= 1'b0;
      valid_r <= 1'b0;
      instr_r <= '0;
      pcout_r <= '0;
    end else begin
      state_r <= state_n;
      pc_r    <= pc_n;
      addr_r  <= addr_n;
      flush_r <= flush_n;
      req_r   <= req_n;
      valid_r <= valid_n;
      instr_r <= instr_n;
      pcout_r <= pcout_n;
    end
  end

  assign imemReq    = req_r;
  assign imemAddr   = addr_r;
  assign instrValid = valid_r;
  assign instr      = instr_r;
  assign opcode     = instr_r[OPCODELEN-1:0];
  assign pcOut      = pcout_r;

`ifdef FETCH_COUNT_EN
  logic [31:0] count_r;

  // Accepted-instruction counter, wraps at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 32'd0;
    end else if (accept_s) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign fetchCount = count_r;
  assign unused_s   = ^branchTarget[1:0];
`else
  assign fetchCount = 32'd0;
  assign unused_s   = ^{branchTarget[1:0], accept_s};
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit; memory returns a fixed hash of
// the address so every delivered word identifies the address it was fetched from.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pcOut;
  logic [31:0] fetchCount;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(
    .ADDRLEN(32), .INSTRLEN(32), .OPCODELEN(7), .RESET_PC(32'h0000_0100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .instrValid(instrValid), .instrReady(instrReady),
    .instr(instr), .opcode(opcode), .pcOut(pcOut), .fetchCount(fetchCount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef FETCH_COUNT_EN
    return 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_instr(input string tag, input logic [31:0] a);
    logic [31:0] w;
    w = memword(a);
    chk({tag, "_valid"}, 64'(instrValid), 64'd1);
    chk({tag, "_pc"}, 64'(pcOut), 64'(a));
    chk({tag, "_instr"}, 64'(instr), 64'(w));
    chk({tag, "_opcode"}, 64'(opcode), 64'(w[6:0]));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, 64'(imemReq), 64'd0);
    chk({tag, "_valid"}, 64'(instrValid), 64'd0);
    chk({tag, "_instr"}, 64'(instr), 64'd0);
    chk({tag, "_opcode"}, 64'(opcode), 64'd0);
    chk({tag, "_pcout"}, 64'(pcOut), 64'd0);
    chk({tag, "_count"}, 64'(fetchCount), 64'd0);
  endtask

  initial begin
    logic [31:0] a, exp_pc, prev_addr;
    logic        prev_req, prev_ack, prev_valid, prev_ready, prev_branch;
    int          n_acc, rand_acc;
    bit          found;

    rst_n = 1'b0; imemAck = 1'b0; imemData = 32'd0;
    branchTaken = 1'b0; branchTarget = 32'd0; instrReady = 1'b0;
    step(); step();
    chk_reset_vals("reset");

    // zero-wait memory, always ready: one instruction every 2 cycles
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      a = 32'h100 + 32'(4 * i);
      chk("seq_req", 64'(imemReq), 64'd1);
      chk("seq_addr", 64'(imemAddr), 64'(a));
      chk("seq_novalid", 64'(instrValid), 64'd0);
      imemAck = 1'b1; imemData = memword(a); instrReady = 1'b1;
      step();
      imemAck = 1'b0; imemData = 32'hDEAD_BEEF;
      chk_instr("seq", a);
      chk("seq_reqlow", 64'(imemReq), 64'd0);
      step();
    end
    chk("seq_count", 64'(fetchCount), 64'(cnt_exp(3)));

    // delayed ack and stalled consumer
    instrReady = 1'b0;
    repeat (3) begin
      step();
      chk("wait_req", 64'(imemReq), 64'd1);
      chk("wait_addr", 64'(imemAddr), 64'h10C);
      chk("wait_novalid", 64'(instrValid), 64'd0);
    end
    imemAck = 1'b1; imemData = memword(32'h10C);
    step();
    imemAck = 1'b0; imemData = 32'h0BAD_F00D;
    repeat (4) begin
      chk_instr("stall", 32'h10C);
      chk("stall_reqlow", 64'(imemReq), 64'd0);
      step();
    end
    chk_instr("stall_end", 32'h10C);
    instrReady = 1'b1;
    step();
    chk("accept_novalid", 64'(instrValid), 64'd0);
    chk("accept_addr", 64'(imemAddr), 64'h110);
    chk("accept_count", 64'(fetchCount), 64'(cnt_exp(4)));

    // redirect in HOLD wins over a simultaneous accept
    imemAck = 1'b1; imemData = memword(32'h110); instrReady = 1'b0;
    step();
    imemAck = 1'b0;
    chk_instr("hold", 32'h110);
    branchTaken = 1'b1; branchTarget = 32'h203; instrReady = 1'b1;
    step();
    branchTaken = 1'b0;
    chk("hbr_novalid", 64'(instrValid), 64'd0);
    chk("hbr_req", 64'(imemReq), 64'd1);
    chk("hbr_addr", 64'(imemAddr), 64'h200);
    chk("hbr_count", 64'(fetchCount), 64'(cnt_exp(4)));

    // redirect in REQ one cycle before a delayed ack
    branchTaken = 1'b1; branchTarget = 32'h40;
    step();
    branchTaken = 1'b0;
    chk("flush_addr_old", 64'(imemAddr), 64'h200);
    chk("flush_req", 64'(imemReq), 64'd1);
    imemAck = 1'b1; imemData = memword(32'h200);
    step();
    imemAck = 1'b0;
    chk("flush_discard", 64'(instrValid), 64'd0);
    chk("flush_addr_new", 64'(imemAddr), 64'h40);
    imemAck = 1'b1; imemData = memword(32'h40);
    step();
    imemAck = 1'b0;
    chk_instr("flush_tgt", 32'h40);
    step();
    chk("five_count", 64'(fetchCount), 64'(cnt_exp(5)));
    chk("after40_addr", 64'(imemAddr), 64'h44);

    // redirect with same-cycle ack, then wrap past the top of memory
    branchTaken = 1'b1; branchTarget = 32'hFFFF_FFFE;
    imemAck = 1'b1; imemData = memword(32'h44);
    step();
    branchTaken = 1'b0;
    chk("brack_novalid", 64'(instrValid), 64'd0);
    chk("brack_addr", 64'(imemAddr), 64'hFFFF_FFFC);
    imemData = memword(32'hFFFF_FFFC);
    step();
    imemAck = 1'b0;
    chk_instr("top", 32'hFFFF_FFFC);
    step();
    chk("wrap_req", 64'(imemReq), 64'd1);
    chk("wrap_addr", 64'(imemAddr), 64'h0);
    n_acc = 6;
    chk("wrap_count", 64'(fetchCount), 64'(cnt_exp(n_acc)));

    // randomized traffic against a program-order model
    exp_pc = 32'h0; rand_acc = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_valid = 1'b0;
    prev_ready = 1'b0; prev_branch = 1'b0; prev_addr = 32'd0;
    for (int i = 0; i < 800; i++) begin
      if (instrValid) chk_instr("rnd", exp_pc);
      if (prev_req && !prev_ack) begin
        chk("rnd_req_hold", 64'(imemReq), 64'd1);
        chk("rnd_addr_hold", 64'(imemAddr), 64'(prev_addr));
      end
      if (prev_branch) chk("rnd_br_drop", 64'(instrValid), 64'd0);
      if (prev_valid && !prev_ready && !prev_branch)
        chk("rnd_valid_hold", 64'(instrValid), 64'd1);

      imemAck      = imemReq && ($urandom_range(0, 1) == 0);
      imemData     = imemAck ? memword(imemAddr) : $urandom;
      instrReady   = ($urandom_range(0, 1) == 0);
      branchTaken  = ($urandom_range(0, 15) == 0);
      branchTarget = $urandom;

      if (branchTaken) begin
        exp_pc = {branchTarget[31:2], 2'b00};
      end else if (instrValid && instrReady) begin
        exp_pc = exp_pc + 32'd4;
        n_acc++;
        rand_acc++;
      end

      prev_req = imemReq; prev_ack = imemAck; prev_addr = imemAddr;
      prev_valid = instrValid; prev_ready = instrReady; prev_branch = branchTaken;
      step();
    end
    branchTaken = 1'b0; imemAck = 1'b0;
    chk("rnd_count", 64'(fetchCount), 64'(cnt_exp(n_acc)));
    chk("rnd_progress", 64'(rand_acc > 20), 64'd1);

    // reset in the middle of a request; an ack during reset is ignored
    instrReady = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imemReq) found = 1'b1;
      else step();
    end
    chk("mid_req_found", 64'(found), 64'd1);
    rst_n = 1'b0; imemAck = 1'b1; imemData = 32'h1234_5678;
    #1;
    chk_reset_vals("async_rst");
    step();
    chk_reset_vals("rst_ack");
    imemAck = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rerun_req", 64'(imemReq), 64'd1);
    chk("rerun_addr", 64'(imemAddr), 64'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
